mpu_host_reader: RTL and testbench

- Host-memory read engine directly downstream of the MPU core's host-memory port.
- Accepts one 64-bit read request (hm_addr/hm_start) at a time.
- Fetches the word as two 32-bit beats over a simple req/ack host bus and returns the assembled 64-bit word as a one-cycle hm_en strobe.
- Reports misalignment and bus timeout through hm_err, so the MPU never hangs on a dead host bus.

---
 rtl/mpu_pkg.sv | 21 ++
 rtl/mpu_host_reader_if.sv | 27 ++
 rtl/mpu_host_timeout.sv | 32 +++
 rtl/mpu_host_reader.sv | 132 +++++++++++++
 tb/tb_mpu_host_reader.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/mpu_pkg.sv
// Shared definitions for the MPU host-memory read path: FSM encoding,
// beat geometry and the default error word.
package mpu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_LO = 2'd1,
    REQ_HI = 2'd2,
    DONE   = 2'd3
  } hm_state_e;

  // A 64-bit host word travels as two 32-bit beats, low address first.
  localparam logic [63:0] HM_BEAT_BYTES = 64'd4;

  localparam logic [63:0] HM_ERR_DATA_DEFAULT = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic logic hm_is_aligned(input logic [2:0] addr_lsb);
    return addr_lsb == 3'b000;
  endfunction

endpackage

// File: rtl/mpu_host_reader_if.sv
// MPU-side request/response signals and host-bus read signals of the reader.
// The master modport is the reader itself; slave is the MPU + host bus side.
interface mpu_host_reader_if;

  logic [63:0] hm_addr;
  logic        hm_start;
  logic [63:0] hm_data;
  logic        hm_en;
  logic        hm_err;
  logic        busy;

  logic [63:0] bus_addr;
  logic        bus_req;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    input  hm_addr, hm_start, bus_ack, bus_rdata,
    output hm_data, hm_en, hm_err, busy, bus_addr, bus_req
  );

  modport slave (
    output hm_addr, hm_start, bus_ack, bus_rdata,
    input  hm_data, hm_en, hm_err, busy, bus_addr, bus_req
  );

endinterface

// File: rtl/mpu_host_timeout.sv
// Per-beat wait counter: cleared by the owner, counts stalled cycles and
// flags the cycle in which the TIMEOUT-th consecutive stall is reached.
module mpu_host_timeout #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  localparam int unsigned   CW   = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;

  assign expire = (cnt_q == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && !expire) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/mpu_host_reader.sv
// Host-memory read engine: fetches one aligned 64-bit word as two 32-bit
// req/ack beats and returns it to the MPU with a one-cycle hm_en strobe.
module mpu_host_reader
  import mpu_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 1024,
  parameter logic [63:0] ERR_DATA = HM_ERR_DATA_DEFAULT
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  mpu_host_reader_if.master io
);

  hm_state_e   state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [31:0] lo_q, lo_d;
  logic        err_q, err_d;
  logic [63:0] bus_addr_q, bus_addr_d;
  logic        bus_req_q, bus_req_d;
  logic [63:0] hm_data_q, hm_data_d;

  logic in_req;
  logic tmo_expire;

  assign in_req = (state_q == REQ_LO) || (state_q == REQ_HI);

  // The counter restarts on every accepted beat and whenever no beat is
  // outstanding, so entry into either REQ state always sees a zero count.
  mpu_host_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk    (sys_clk),
    .rst_n  (sys_rst),
    .clr    (!in_req || io.bus_ack),
    .inc    (in_req && !io.bus_ack),
    .expire (tmo_expire)
  );

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      lo_q       <= '0;
      err_q      <= 1'b0;
      bus_addr_q <= '0;
      bus_req_q  <= 1'b0;
      hm_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      lo_q       <= lo_d;
      err_q      <= err_d;
      bus_addr_q <= bus_addr_d;
      bus_req_q  <= bus_req_d;
      hm_data_q  <= hm_data_d;
    end
  end

  // NOTE: every signal assigned below gets its hold value first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    lo_d       = lo_q;
    err_d      = err_q;
    bus_addr_d = bus_addr_q;
    bus_req_d  = bus_req_q;
    hm_data_d  = hm_data_q;

    unique case (state_q)
      IDLE: begin
        if (io.hm_start) begin
          addr_d = io.hm_addr;
          if (!hm_is_aligned(io.hm_addr[2:0])) begin
            err_d     = 1'b1;
            hm_data_d = ERR_DATA;
            state_d   = DONE;
          end else begin
            err_d      = 1'b0;
            bus_addr_d = io.hm_addr;
            bus_req_d  = 1'b1;
            state_d    = REQ_LO;
          end
        end
      end

      REQ_LO: begin
        if (io.bus_ack) begin
          lo_d       = io.bus_rdata;
          bus_addr_d = addr_q + HM_BEAT_BYTES;
          state_d    = REQ_HI;
        end else if (tmo_expire) begin
          bus_req_d = 1'b0;
          err_d     = 1'b1;
          hm_data_d = ERR_DATA;
          state_d   = DONE;
        end
      end

      REQ_HI: begin
        // An ack in the expiry cycle still wins over the timeout.
        if (io.bus_ack) begin
          bus_req_d = 1'b0;
          err_d     = 1'b0;
          hm_data_d = {io.bus_rdata, lo_q};
          state_d   = DONE;
        end else if (tmo_expire) begin
          bus_req_d = 1'b0;
          err_d     = 1'b1;
          hm_data_d = ERR_DATA;
          state_d   = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign io.hm_en    = (state_q == DONE);
  assign io.hm_err   = (state_q == DONE) && err_q;
  assign io.hm_data  = hm_data_q;
  assign io.busy     = (state_q != IDLE);
  assign io.bus_addr = bus_addr_q;
  assign io.bus_req  = bus_req_q;

endmodule

// File: tb/tb_mpu_host_reader.sv
// Randomised bench for mpu_host_reader: a cycle-level bus responder plus a
// timing/data model derived from the read rules predicts every completion.
module tb_mpu_host_reader;

  localparam int          TO      = 8;
  localparam logic [63:0] ERR_VAL = 64'hFFFF_FFFF_FFFF_FFFF;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;

  mpu_host_reader_if bus_if ();

  mpu_host_reader #(
    .TIMEOUT  (TO),
    .ERR_DATA (ERR_VAL)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .io      (bus_if)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Host memory contents as seen by the bus responder.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h1000) return 32'h1122_3344;
    if (a == 64'h1004) return 32'h5566_7788;
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
  endfunction

  // spam: 0 = no extra starts, 1 = one extra start at cycle 1,
  // 2 = random extra starts on every busy cycle (including DONE).
  task automatic do_read(input logic [63:0] addr, input int w_lo, input int w_hi,
                         input int spam, output logic [63:0] got_data);
    int          lat;
    bit          aligned;
    bit          exp_err;
    logic [63:0] exp_data;
    int          en_cnt   = 0;
    int          en_cyc   = -1;
    logic        got_err  = 1'b0;
    int          busy_bad = 0;
    int          req_bad  = 0;
    int          beat     = 0;
    int          waitc    = 0;
    int          w[2];

    got_data = 'x;
    w[0]     = w_lo;
    w[1]     = w_hi;
    aligned  = (addr % 8) == 0;
    if (!aligned)         begin lat = 1;                 exp_err = 1'b1; end
    else if (w_lo >= TO)  begin lat = TO + 1;            exp_err = 1'b1; end
    else if (w_hi >= TO)  begin lat = 2 + w_lo + TO;     exp_err = 1'b1; end
    else                  begin lat = 3 + w_lo + w_hi;   exp_err = 1'b0; end
    exp_data = exp_err ? ERR_VAL : {mem_word(addr + 4), mem_word(addr)};

    for (int cyc = 0; cyc <= lat + 3; cyc++) begin
      @(posedge sys_clk);
      #1;
      if (cyc == 0) begin
        bus_if.hm_start = 1'b1;
        bus_if.hm_addr  = addr;
      end else if ((spam == 1 && cyc == 1) || (spam == 2 && cyc <= lat)) begin
        bus_if.hm_start = (spam == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        bus_if.hm_addr  = addr ^ {$urandom, $urandom} ^ 64'h8;
      end else begin
        bus_if.hm_start = 1'b0;
        bus_if.hm_addr  = {$urandom, $urandom};
      end

      if (bus_if.bus_req) begin
        if (beat < 2 && waitc == w[beat]) begin
          check($sformatf("bus_addr_b%0d", beat), bus_if.bus_addr, addr + 64'(4 * beat));
          bus_if.bus_ack   = 1'b1;
          bus_if.bus_rdata = mem_word(addr + 64'(4 * beat));
          beat++;
          waitc = 0;
        end else begin
          bus_if.bus_ack   = 1'b0;
          bus_if.bus_rdata = $urandom;
          waitc++;
        end
      end else begin
        // Stray acks while no request is outstanding must be ignored.
        bus_if.bus_ack   = 1'($urandom_range(0, 1));
        bus_if.bus_rdata = $urandom;
      end

      @(negedge sys_clk);
      if (bus_if.busy !== (cyc >= 1 && cyc <= lat)) busy_bad++;
      if (bus_if.bus_req !== (aligned && cyc >= 1 && cyc < lat)) req_bad++;
      if (bus_if.hm_en === 1'b1) begin
        en_cnt++;
        en_cyc   = cyc;
        got_data = bus_if.hm_data;
        got_err  = bus_if.hm_err;
      end
    end
    bus_if.hm_start = 1'b0;
    bus_if.bus_ack  = 1'b0;

    check("en_count", 64'(en_cnt), 64'd1);
    check("en_cycle", 64'(en_cyc), 64'(lat));
    check("hm_err",   64'(got_err), 64'(exp_err));
    check("hm_data",  got_data, exp_data);
    check("data_held", bus_if.hm_data, exp_data);
    check("busy_profile", 64'(busy_bad), 64'd0);
    check("req_profile",  64'(req_bad), 64'd0);
  endtask

  logic [63:0] rd;

  initial begin
    bus_if.hm_addr   = '0;
    bus_if.hm_start  = 1'b0;
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = '0;

    repeat (2) @(negedge sys_clk);
    check("rst_hm_en",    64'(bus_if.hm_en), 64'd0);
    check("rst_hm_err",   64'(bus_if.hm_err), 64'd0);
    check("rst_hm_data",  bus_if.hm_data, 64'd0);
    check("rst_busy",     64'(bus_if.busy), 64'd0);
    check("rst_bus_req",  64'(bus_if.bus_req), 64'd0);
    check("rst_bus_addr", bus_if.bus_addr, 64'd0);
    sys_rst = 1'b1;
    repeat (2) @(negedge sys_clk);

    // Zero-wait, wait-state, misaligned and timeout reads.
    do_read(64'h1000, 0, 0, 0, rd);
    check("zero_wait_word", rd, 64'h5566_7788_1122_3344);
    do_read(64'h1000, 5, 2, 0, rd);
    check("wait_state_word", rd, 64'h5566_7788_1122_3344);
    do_read(64'h1003, 0, 0, 0, rd);
    check("misaligned_word", rd, ERR_VAL);
    do_read(64'h3000, 0, 50, 0, rd);
    do_read(64'h3000, 1, 1, 0, rd);
    do_read(64'h4000, TO, 0, 0, rd);
    do_read(64'h4008, TO - 1, TO - 1, 0, rd);
    do_read(64'hFFFF_FFFF_FFFF_FFF8, 0, 0, 0, rd);

    // Start while busy, then starts on every busy cycle including DONE.
    do_read(64'h5000, 2, 1, 1, rd);
    do_read(64'h5008, 0, 3, 2, rd);

    // Reset during REQ_HI abandons the read.
    @(posedge sys_clk); #1;
    bus_if.hm_start = 1'b1;
    bus_if.hm_addr  = 64'h6000;
    @(posedge sys_clk); #1;
    bus_if.hm_start  = 1'b0;
    bus_if.bus_ack   = 1'b1;
    bus_if.bus_rdata = 32'hCAFE_0001;
    @(posedge sys_clk); #1;
    bus_if.bus_ack = 1'b0;
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    #1;
    check("rst_mid_bus_req", 64'(bus_if.bus_req), 64'd0);
    check("rst_mid_busy",    64'(bus_if.busy), 64'd0);
    check("rst_mid_hm_en",   64'(bus_if.hm_en), 64'd0);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    begin
      int stray_en = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge sys_clk);
        if (bus_if.hm_en !== 1'b0 || bus_if.busy !== 1'b0) stray_en++;
      end
      check("rst_no_completion", 64'(stray_en), 64'd0);
    end
    do_read(64'h6000, 1, 0, 0, rd);

    // Randomised reads with mixed alignment, wait states and start noise.
    for (int n = 0; n < 40; n++) begin
      logic [63:0] a;
      a = {$urandom, $urandom};
      if ($urandom_range(0, 7) != 0) a[2:0] = 3'b000;
      do_read(a, $urandom_range(0, TO + 1), $urandom_range(0, TO + 1),
              $urandom_range(0, 2), rd);
      repeat ($urandom_range(0, 2)) @(negedge sys_clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
